// File: rtl/reg_bank_pkg.sv
// Shared opcode encodings and the rule that decides which opcodes execute.
// Codes above OP_ROR are reserved and behave like HOLD.
package reg_bank_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_HOLD  = 4'd0,
        OP_LOAD  = 4'd1,
        OP_CLEAR = 4'd2,
        OP_SET   = 4'd3,
        OP_INC   = 4'd4,
        OP_DEC   = 4'd5,
        OP_SHL   = 4'd6,
        OP_SHR   = 4'd7,
        OP_ROL   = 4'd8,
        OP_ROR   = 4'd9
    } op_e;

    function automatic logic op_valid(logic [OP_W-1:0] code);
        return (code != OP_HOLD) && (code <= OP_ROR);
    endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Operation and read-port bundle for reg_bank; the master drives operations
// and read selects, the slave (the bank) returns read data and flags.
interface reg_bank_if
    import reg_bank_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int NUM_REGS  = 8
);
    localparam int SEL_W = $clog2(NUM_REGS);

    logic                 opEnable;
    logic [OP_W-1:0]      opCode;
    logic [SEL_W-1:0]     opSel;
    logic [WORD_SIZE-1:0] opData;
    logic                 serialIn;
    logic [SEL_W-1:0]     rdSelA;
    logic [SEL_W-1:0]     rdSelB;
    logic [WORD_SIZE-1:0] rdDataA;
    logic [WORD_SIZE-1:0] rdDataB;
    logic                 zeroFlag;
    logic                 carryFlag;

    modport master (
        output opEnable, opCode, opSel, opData, serialIn, rdSelA, rdSelB,
        input  rdDataA, rdDataB, zeroFlag, carryFlag
    );

    modport slave (
        input  opEnable, opCode, opSel, opData, serialIn, rdSelA, rdSelB,
        output rdDataA, rdDataB, zeroFlag, carryFlag
    );
endinterface

// File: rtl/reg_bank_alu.sv
// Combinational next-value/carry for one register under one opcode.
// valid_o is low for HOLD and reserved codes so the bank can skip the write.
module reg_bank_alu
    import reg_bank_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0]    r_i,
    input  logic [OP_W-1:0] op_code_i,
    input  logic [W-1:0]    op_data_i,
    input  logic            serial_i,
    output logic [W-1:0]    nxt_o,
    output logic            carry_o,
    output logic            valid_o
);
    assign valid_o = op_valid(op_code_i);

    always_comb begin
        nxt_o   = r_i;
        carry_o = 1'b0;
        case (op_code_i)
            OP_LOAD:  nxt_o = op_data_i;
            OP_CLEAR: nxt_o = '0;
            OP_SET:   nxt_o = '1;
            OP_INC: begin
                nxt_o   = r_i + W'(1);
                carry_o = &r_i;
            end
            OP_DEC: begin
                nxt_o   = r_i - W'(1);
                carry_o = ~|r_i;
            end
            OP_SHL: begin
                nxt_o   = {r_i[W-2:0], serial_i};
                carry_o = r_i[W-1];
            end
            OP_SHR: begin
                nxt_o   = {serial_i, r_i[W-1:1]};
                carry_o = r_i[0];
            end
            OP_ROL: begin
                nxt_o   = {r_i[W-2:0], r_i[W-1]};
                carry_o = r_i[W-1];
            end
            OP_ROR: begin
                nxt_o   = {r_i[0], r_i[W-1:1]};
                carry_o = r_i[0];
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/reg_bank.sv
// Architectural register file: one op port writing one register per cycle,
// two combinational read ports, registered zero/carry flags of the last op.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int NUM_REGS  = 8
) (
    input  logic       clk,
    input  logic       rstN,
    reg_bank_if.slave  bus
);
    localparam int SEL_W = $clog2(NUM_REGS);

    logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
    logic [WORD_SIZE-1:0] regs_d [NUM_REGS];
    logic                 zero_q, zero_d;
    logic                 carry_q, carry_d;

    logic [WORD_SIZE-1:0] tgt_val;
    logic                 sel_hit;
    logic [WORD_SIZE-1:0] alu_nxt;
    logic                 alu_carry;
    logic                 alu_valid;
    logic                 exec;
    logic [WORD_SIZE-1:0] rd_a, rd_b;

    // Select decode doubles as the range check: out-of-range selects never hit.
    always_comb begin
        tgt_val = '0;
        sel_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.opSel == SEL_W'(i)) begin
                tgt_val = regs_q[i];
                sel_hit = 1'b1;
            end
        end
    end

    reg_bank_alu #(.W(WORD_SIZE)) u_alu (
        .r_i       (tgt_val),
        .op_code_i (bus.opCode),
        .op_data_i (bus.opData),
        .serial_i  (bus.serialIn),
        .nxt_o     (alu_nxt),
        .carry_o   (alu_carry),
        .valid_o   (alu_valid)
    );

    assign exec = bus.opEnable & alu_valid & sel_hit;

    always_comb begin
        regs_d  = regs_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        if (exec) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bus.opSel == SEL_W'(i)) regs_d[i] = alu_nxt;
            end
            zero_d  = ~|alu_nxt;
            carry_d = alu_carry;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    // Reads see stored contents only; a same-cycle write shows up after the edge.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.rdSelA == SEL_W'(i)) rd_a = regs_q[i];
            if (bus.rdSelB == SEL_W'(i)) rd_b = regs_q[i];
        end
    end

    assign bus.rdDataA   = rd_a;
    assign bus.rdDataB   = rd_b;
    assign bus.zeroFlag  = zero_q;
    assign bus.carryFlag = carry_q;
endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank (16-bit, 6 registers): directed literal checks plus
// randomized ops compared every cycle against an arithmetic reference model.
module tb_reg_bank;
    localparam int W    = 16;
    localparam int NR   = 6;
    localparam int MASK = (1 << W) - 1;

    logic clk = 1'b0;
    logic rstN;
    reg_bank_if #(.WORD_SIZE(W), .NUM_REGS(NR)) bus ();

    reg_bank #(.WORD_SIZE(W), .NUM_REGS(NR)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    int m_reg [NR];
    int m_z;
    int m_c;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Result/carry of one op from the arithmetic definition of each opcode.
    function automatic void model_op(input int code, input int r, input int data,
                                     input int si, output int res, output int c);
        res = r;
        c   = 0;
        case (code)
            1: res = data & MASK;
            2: res = 0;
            3: res = MASK;
            4: begin res = (r + 1) % (MASK + 1); c = (r == MASK); end
            5: begin res = (r + MASK) % (MASK + 1); c = (r == 0); end
            6: begin res = (r * 2 + si) % (MASK + 1); c = r / (1 << (W - 1)); end
            7: begin res = r / 2 + si * (1 << (W - 1)); c = r % 2; end
            8: begin res = (r * 2) % (MASK + 1) + r / (1 << (W - 1)); c = r / (1 << (W - 1)); end
            9: begin res = r / 2 + (r % 2) * (1 << (W - 1)); c = r % 2; end
            default: ;
        endcase
    endfunction

    always @(posedge clk or negedge rstN) begin
        int res, c;
        if (!rstN) begin
            for (int i = 0; i < NR; i++) m_reg[i] <= 0;
            m_z <= 1;
            m_c <= 0;
        end else if (bus.opEnable && int'(bus.opSel) < NR
                     && bus.opCode >= 1 && bus.opCode <= 9) begin
            model_op(int'(bus.opCode), m_reg[bus.opSel], int'(bus.opData),
                     int'(bus.serialIn), res, c);
            m_reg[bus.opSel] <= res;
            m_z <= (res == 0);
            m_c <= c;
        end
    end

    function automatic int m_rd(input int sel);
        return (sel < NR) ? m_reg[sel] : 0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rdA", int'(bus.rdDataA), m_rd(int'(bus.rdSelA)));
            chk("rdB", int'(bus.rdDataB), m_rd(int'(bus.rdSelB)));
            chk("zero", int'(bus.zeroFlag), m_z);
            chk("carry", int'(bus.carryFlag), m_c);
        end
    end

    task automatic op(input int code, input int sel, input int data, input int si);
        bus.opEnable = 1'b1;
        bus.opCode   = 4'(code);
        bus.opSel    = 3'(sel);
        bus.opData   = 16'(data);
        bus.serialIn = 1'(si);
        @(posedge clk);
        #2;
        bus.opEnable = 1'b0;
    endtask

    task automatic rd(input int a, input int b);
        bus.rdSelA = 3'(a);
        bus.rdSelB = 3'(b);
        #1;
    endtask

    initial begin
        rstN = 1'b1;
        bus.opEnable = 1'b0;
        bus.opCode   = '0;
        bus.opSel    = '0;
        bus.opData   = '0;
        bus.serialIn = 1'b0;
        bus.rdSelA   = 3'd3;
        bus.rdSelB   = 3'd0;
        #1 rstN = 1'b0;
        #1;
        chk("rst_rdA", int'(bus.rdDataA), 0);
        chk("rst_rdB", int'(bus.rdDataB), 0);
        chk("rst_zero", int'(bus.zeroFlag), 1);
        chk("rst_carry", int'(bus.carryFlag), 0);
        #10 rstN = 1'b1;
        chk_en = 1'b1;

        // LOAD r3: old value visible in the write cycle, new value after the edge
        bus.opEnable = 1'b1; bus.opCode = 4'd1; bus.opSel = 3'd3; bus.opData = 16'h1234;
        rd(3, 3);
        chk("load_same_cycle", int'(bus.rdDataA), 0);
        @(posedge clk); #2; bus.opEnable = 1'b0;
        chk("load_rdA", int'(bus.rdDataA), 'h1234);
        chk("load_rdB", int'(bus.rdDataB), 'h1234);
        chk("load_zero", int'(bus.zeroFlag), 0);
        chk("load_carry", int'(bus.carryFlag), 0);

        // wrap on INC and DEC
        rd(0, 0);
        op(1, 0, 'hFFFF, 0);
        op(4, 0, 0, 0);
        chk("inc_wrap", int'(bus.rdDataA), 0);
        chk("inc_zero", int'(bus.zeroFlag), 1);
        chk("inc_carry", int'(bus.carryFlag), 1);
        op(5, 0, 0, 0);
        chk("dec_wrap", int'(bus.rdDataA), 'hFFFF);
        chk("dec_zero", int'(bus.zeroFlag), 0);
        chk("dec_carry", int'(bus.carryFlag), 1);

        // shifts and rotates on r1
        rd(1, 1);
        op(1, 1, 'h8001, 0);
        op(6, 1, 0, 0);
        chk("shl", int'(bus.rdDataA), 'h0002);
        chk("shl_carry", int'(bus.carryFlag), 1);
        op(9, 1, 0, 0);
        chk("ror1", int'(bus.rdDataA), 'h0001);
        chk("ror1_carry", int'(bus.carryFlag), 0);
        op(9, 1, 0, 0);
        chk("ror2", int'(bus.rdDataA), 'h8000);
        chk("ror2_carry", int'(bus.carryFlag), 1);

        // masked ops: out-of-range select, disabled, reserved opcode
        op(2, 7, 0, 0);
        op(2, 6, 0, 0);
        chk("oor_sel_keep", int'(bus.rdDataA), 'h8000);
        chk("oor_sel_flag", int'(bus.carryFlag), 1);
        bus.opEnable = 1'b0; bus.opCode = 4'd2; bus.opSel = 3'd1;
        @(posedge clk); #2;
        chk("disabled_keep", int'(bus.rdDataA), 'h8000);
        op(12, 1, 0, 0);
        chk("reserved_keep", int'(bus.rdDataA), 'h8000);
        chk("reserved_zero", int'(bus.zeroFlag), 0);
        chk("reserved_carry", int'(bus.carryFlag), 1);
        rd(6, 7);
        chk("rd_sel6", int'(bus.rdDataA), 0);
        chk("rd_sel7", int'(bus.rdDataB), 0);

        // async reset overriding a pending LOAD
        bus.opEnable = 1'b1; bus.opCode = 4'd1; bus.opSel = 3'd2; bus.opData = 16'h5555;
        rd(2, 3);
        rstN = 1'b0;
        #1;
        chk("arst_r3", int'(bus.rdDataB), 0);
        chk("arst_zero", int'(bus.zeroFlag), 1);
        @(posedge clk); #2;
        rstN = 1'b1;
        bus.opEnable = 1'b0;
        @(posedge clk); #2;
        chk("arst_load_lost", int'(bus.rdDataA), 0);

        // random traffic checked every cycle by the compare process
        for (int k = 0; k < 600; k++) begin
            bus.opEnable = 1'($urandom_range(0, 9) != 0);
            bus.opCode   = 4'($urandom_range(0, 15));
            bus.opSel    = 3'($urandom_range(0, 7));
            bus.opData   = 16'($urandom_range(0, 3) == 0 ? (($urandom_range(0, 1) == 0) ? 0 : MASK)
                                                         : $urandom_range(0, MASK));
            bus.serialIn = 1'($urandom_range(0, 1));
            bus.rdSelA   = 3'($urandom_range(0, 7));
            bus.rdSelB   = 3'($urandom_range(0, 7));
            @(posedge clk); #2;
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
